// File: rtl/sl_fifo_pkg.sv
// Shared definitions for the FX3 slave-FIFO responder: thread codes, widths,
// the F2U entry layout and the read pipe depth.
package sl_fifo_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned RD_LATENCY = 2;

    localparam logic [1:0] AD_U2F = 2'b00;
    localparam logic [1:0] AD_F2U = 2'b11;

    typedef struct packed {
        logic              zlp;
        logic              last;
        logic [DATA_W-1:0] data;
    } f2u_entry_t;

    localparam int unsigned F2U_W = $bits(f2u_entry_t);

endpackage

// File: rtl/sl_fifo_sync.sv
// Synchronous first-word-fall-through FIFO with occupancy count and
// per-cycle accept strobes so the parent can track the next count.
module sl_fifo_sync #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 512,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          push_ok_c,
    output logic          pop_ok_c
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // A pop on a full buffer frees the slot first; a push into an empty one cannot be popped.
    always_comb begin
        pop_ok_c  = pop & (count != '0);
        push_ok_c = push & ((count != CW'(DEPTH)) | pop_ok_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok_c)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok_c) - CW'(pop_ok_c);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/sl_fifo_responder.sv
// FX3 GPIF-II slave-FIFO device model: serves master reads from the U2F
// buffer, captures master writes into F2U, and exposes both to the host side.
module sl_fifo_responder
    import sl_fifo_pkg::*;
#(
    parameter int unsigned P_DEPTH_U2F = 512,
    parameter int unsigned P_DEPTH_F2U = 512,
    parameter int unsigned P_WMARK     = 16,
    parameter logic [1:0]  P_AD_U2F    = AD_U2F,
    parameter logic [1:0]  P_AD_F2U    = AD_F2U
) (
    input  logic              SL_PCLK,
    input  logic              SL_RST_N,
    input  logic              SL_CS_N,
    input  logic              SL_RD_N,
    input  logic              SL_WR_N,
    input  logic              SL_OE_N,
    input  logic              SL_PKTEND_N,
    input  logic [1:0]        SL_AD,
    inout  wire  [DATA_W-1:0] SL_DT,
    output logic              SL_FLAGA,
    output logic              SL_FLAGB,
    output logic              SL_FLAGC,
    output logic              SL_FLAGD,
    input  logic              H_U2F_TVALID,
    output logic              H_U2F_TREADY,
    input  logic [DATA_W-1:0] H_U2F_TDATA,
    output logic              H_F2U_TVALID,
    input  logic              H_F2U_TREADY,
    output logic [DATA_W-1:0] H_F2U_TDATA,
    output logic              H_F2U_TLAST,
    output logic              H_F2U_TZLP,
    output logic              ERR_OVF,
    output logic              ERR_UNF,
    output logic              ERR_PROTO
);

    localparam int unsigned U2F_CW = $clog2(P_DEPTH_U2F) + 1;
    localparam int unsigned F2U_CW = $clog2(P_DEPTH_F2U) + 1;

    logic rd_any, wr_any, pkt_only, rd_u2f, wr_f2u, zlp_f2u, f2u_push, proto_c;

    // Strobe decode; a pktend-only cycle is a strobe on the F2U thread.
    always_comb begin
        rd_any   = ~SL_CS_N & ~SL_RD_N & SL_WR_N;
        wr_any   = ~SL_CS_N & ~SL_WR_N & SL_RD_N;
        pkt_only = ~SL_CS_N & SL_RD_N & SL_WR_N & ~SL_PKTEND_N;
        rd_u2f   = rd_any & (SL_AD == P_AD_U2F);
        wr_f2u   = wr_any & (SL_AD == P_AD_F2U);
        zlp_f2u  = pkt_only & (SL_AD == P_AD_F2U);
        f2u_push = wr_f2u | zlp_f2u;
        proto_c  = (~SL_CS_N & ~SL_RD_N & ~SL_WR_N) | (rd_any & ~rd_u2f)
                 | (wr_any & ~wr_f2u) | (pkt_only & ~zlp_f2u);
    end

    f2u_entry_t f2u_wentry;
    f2u_entry_t f2u_rentry;

    always_comb begin
        f2u_wentry = '0;
        if (wr_f2u) begin
            f2u_wentry.last = ~SL_PKTEND_N;
            f2u_wentry.data = SL_DT;
        end else begin
            f2u_wentry.zlp  = 1'b1;
            f2u_wentry.last = 1'b1;
        end
    end

    logic [DATA_W-1:0] u2f_rdata;
    logic [U2F_CW-1:0] u2f_cnt, u2f_cnt_nxt;
    logic [F2U_CW-1:0] f2u_cnt, f2u_cnt_nxt;
    logic              u2f_push_ok, u2f_pop_ok, f2u_push_ok, f2u_pop_ok;

    sl_fifo_sync #(.W(DATA_W), .DEPTH(P_DEPTH_U2F)) u_u2f (
        .clk       (SL_PCLK),
        .rst_n     (SL_RST_N),
        .push      (H_U2F_TVALID & H_U2F_TREADY),
        .wdata     (H_U2F_TDATA),
        .pop       (rd_u2f),
        .rdata     (u2f_rdata),
        .count     (u2f_cnt),
        .push_ok_c (u2f_push_ok),
        .pop_ok_c  (u2f_pop_ok)
    );

    sl_fifo_sync #(.W(F2U_W), .DEPTH(P_DEPTH_F2U)) u_f2u (
        .clk       (SL_PCLK),
        .rst_n     (SL_RST_N),
        .push      (f2u_push),
        .wdata     (f2u_wentry),
        .pop       (H_F2U_TVALID & H_F2U_TREADY),
        .rdata     (f2u_rentry),
        .count     (f2u_cnt),
        .push_ok_c (f2u_push_ok),
        .pop_ok_c  (f2u_pop_ok)
    );

    always_comb begin
        u2f_cnt_nxt = u2f_cnt + U2F_CW'(u2f_push_ok) - U2F_CW'(u2f_pop_ok);
        f2u_cnt_nxt = f2u_cnt + F2U_CW'(f2u_push_ok) - F2U_CW'(f2u_pop_ok);
    end

    logic [DATA_W-1:0] rd_pipe [RD_LATENCY];

    // Flags and host handshakes are registered from the post-edge occupancy.
    always_ff @(posedge SL_PCLK or negedge SL_RST_N) begin
        if (!SL_RST_N) begin
            SL_FLAGA     <= 1'b1;
            SL_FLAGB     <= 1'b1;
            SL_FLAGC     <= 1'b0;
            SL_FLAGD     <= 1'b0;
            H_U2F_TREADY <= 1'b0;
            H_F2U_TVALID <= 1'b0;
            ERR_OVF      <= 1'b0;
            ERR_UNF      <= 1'b0;
            ERR_PROTO    <= 1'b0;
            for (int i = 0; i < RD_LATENCY; i++) rd_pipe[i] <= '0;
        end else begin
            SL_FLAGA     <= f2u_cnt_nxt != F2U_CW'(P_DEPTH_F2U);
            SL_FLAGB     <= (F2U_CW'(P_DEPTH_F2U) - f2u_cnt_nxt) >= F2U_CW'(P_WMARK);
            SL_FLAGC     <= u2f_cnt_nxt != '0;
            SL_FLAGD     <= u2f_cnt_nxt >= U2F_CW'(P_WMARK);
            H_U2F_TREADY <= u2f_cnt_nxt != U2F_CW'(P_DEPTH_U2F);
            H_F2U_TVALID <= f2u_cnt_nxt != '0;
            ERR_OVF      <= ERR_OVF | (f2u_push & ~f2u_push_ok);
            ERR_UNF      <= ERR_UNF | (rd_u2f & ~u2f_pop_ok);
            ERR_PROTO    <= ERR_PROTO | proto_c;
            rd_pipe[0]   <= u2f_pop_ok ? u2f_rdata : '0;
            for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    // Reset releases the bus immediately, independent of the clock.
    logic dt_oe_c;
    assign dt_oe_c = SL_RST_N & ~SL_CS_N & ~SL_OE_N & (SL_AD == P_AD_U2F);
    assign SL_DT   = dt_oe_c ? rd_pipe[RD_LATENCY-1] : {DATA_W{1'bz}};

    assign H_F2U_TDATA = f2u_rentry.data;
    assign H_F2U_TLAST = f2u_rentry.last;
    assign H_F2U_TZLP  = f2u_rentry.zlp;

endmodule

// File: tb/tb_sl_fifo_responder.sv
// Self-checking bench for sl_fifo_responder: single-cycle strobe vectors from
// a table plus scoreboarded burst, packet, fill and mid-burst reset sequences.
module tb_sl_fifo_responder;
    import sl_fifo_pkg::*;

    localparam int unsigned DEPTH = 512;
    localparam int unsigned WMARK = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, oe_n = 1'b1, pktend_n = 1'b1;
    logic [1:0]  ad = 2'b00;
    logic        tb_drv = 1'b0;
    logic [31:0] tb_dt = '0;
    wire  [31:0] sl_dt;
    logic        flaga, flagb, flagc, flagd;
    logic        u2f_tvalid = 1'b0, u2f_tready;
    logic [31:0] u2f_tdata = '0;
    logic        f2u_tvalid, f2u_tready = 1'b0, f2u_tlast, f2u_tzlp;
    logic [31:0] f2u_tdata;
    logic        err_ovf, err_unf, err_proto;

    assign sl_dt = tb_drv ? tb_dt : 32'hzzzz_zzzz;

    always #5 clk = ~clk;

    sl_fifo_responder dut (
        .SL_PCLK(clk), .SL_RST_N(rst_n), .SL_CS_N(cs_n), .SL_RD_N(rd_n), .SL_WR_N(wr_n),
        .SL_OE_N(oe_n), .SL_PKTEND_N(pktend_n), .SL_AD(ad), .SL_DT(sl_dt),
        .SL_FLAGA(flaga), .SL_FLAGB(flagb), .SL_FLAGC(flagc), .SL_FLAGD(flagd),
        .H_U2F_TVALID(u2f_tvalid), .H_U2F_TREADY(u2f_tready), .H_U2F_TDATA(u2f_tdata),
        .H_F2U_TVALID(f2u_tvalid), .H_F2U_TREADY(f2u_tready), .H_F2U_TDATA(f2u_tdata),
        .H_F2U_TLAST(f2u_tlast), .H_F2U_TZLP(f2u_tzlp),
        .ERR_OVF(err_ovf), .ERR_UNF(err_unf), .ERR_PROTO(err_proto)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_exp_t;

    rd_exp_t    rd_q [$];
    f2u_entry_t f2u_q [$];

    typedef struct {
        logic        cs_n, rd_n, wr_n, pktend_n;
        logic [1:0]  ad;
        logic [31:0] dt;
        logic        e_unf, e_proto, e_ovf, e_tvalid, e_tlast, e_tzlp;
        logic [31:0] e_tdata;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Advance one clock; sample just after the edge and retire due read words.
    task automatic tick();
        rd_exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
            e = rd_q.pop_front();
            chk("sl_dt_read", sl_dt, e.data);
        end
    endtask

    task automatic idle();
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; oe_n = 1'b1; pktend_n = 1'b1;
        ad = 2'b00; tb_drv = 1'b0; u2f_tvalid = 1'b0; f2u_tready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        rd_q.delete();
        f2u_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic host_push(input logic [31:0] d);
        u2f_tvalid = 1'b1;
        u2f_tdata  = d;
        tick();
        u2f_tvalid = 1'b0;
    endtask

    task automatic drain(input int budget);
        f2u_entry_t e;
        f2u_tready = 1'b1;
        for (int b = 0; b < budget && f2u_q.size() != 0; b++) begin
            if (f2u_tvalid) begin
                e = f2u_q.pop_front();
                chk("f2u_tdata", f2u_tdata, e.data);
                chk("f2u_tlast", 32'(f2u_tlast), 32'(e.last));
                chk("f2u_tzlp", 32'(f2u_tzlp), 32'(e.zlp));
            end
            tick();
        end
        f2u_tready = 1'b0;
        chk("f2u_drain_left", 32'(f2u_q.size()), 32'd0);
        chk("f2u_tvalid_drained", 32'(f2u_tvalid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          cs rd wr pk  ad     dt            unf pro ovf tv  tl  tz  tdata
        vt[0] = '{1'b0,1'b0,1'b1,1'b1,2'b00,32'h0,        1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0};
        vt[1] = '{1'b0,1'b0,1'b0,1'b1,2'b00,32'h0,        1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0};
        vt[2] = '{1'b0,1'b0,1'b1,1'b1,2'b11,32'h0,        1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0};
        vt[3] = '{1'b0,1'b1,1'b0,1'b1,2'b00,32'h5555_0003,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0};
        vt[4] = '{1'b0,1'b1,1'b0,1'b1,2'b11,32'hCAFE_0004,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'hCAFE_0004};
        vt[5] = '{1'b0,1'b1,1'b0,1'b0,2'b11,32'hBEEF_0005,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,32'hBEEF_0005};
        vt[6] = '{1'b0,1'b1,1'b1,1'b0,2'b11,32'h1111_0006,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,32'h0};
        vt[7] = '{1'b1,1'b0,1'b0,1'b0,2'b11,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0};
        vt[8] = '{1'b0,1'b1,1'b0,1'b1,2'b01,32'h0,        1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0};
        vt[9] = '{1'b0,1'b0,1'b1,1'b1,2'b10,32'h0,        1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0};

        // Reset values, with the bench holding the bus to see it is not driven.
        cs_n = 1'b0; oe_n = 1'b0; ad = 2'b00; tb_drv = 1'b1; tb_dt = 32'h0000_1234;
        repeat (2) tick();
        chk("rst_flaga", 32'(flaga), 32'd1);
        chk("rst_flagb", 32'(flagb), 32'd1);
        chk("rst_flagc", 32'(flagc), 32'd0);
        chk("rst_flagd", 32'(flagd), 32'd0);
        chk("rst_u2f_tready", 32'(u2f_tready), 32'd0);
        chk("rst_f2u_tvalid", 32'(f2u_tvalid), 32'd0);
        chk("rst_errs", {29'd0, err_ovf, err_unf, err_proto}, 32'd0);
        chk("rst_sl_dt_released", sl_dt, 32'h0000_1234);
        idle();
        rst_n = 1'b1;
        tick();
        chk("u2f_tready_after_rst", 32'(u2f_tready), 32'd1);

        // Single-cycle strobe table, each from a fresh reset.
        for (int v = 0; v < 10; v++) begin
            do_reset();
            cs_n = vt[v].cs_n; rd_n = vt[v].rd_n; wr_n = vt[v].wr_n;
            pktend_n = vt[v].pktend_n; ad = vt[v].ad; tb_dt = vt[v].dt; tb_drv = 1'b1;
            tick();
            idle();
            chk($sformatf("vec%0d_err_unf", v), 32'(err_unf), 32'(vt[v].e_unf));
            chk($sformatf("vec%0d_err_proto", v), 32'(err_proto), 32'(vt[v].e_proto));
            chk($sformatf("vec%0d_err_ovf", v), 32'(err_ovf), 32'(vt[v].e_ovf));
            chk($sformatf("vec%0d_tvalid", v), 32'(f2u_tvalid), 32'(vt[v].e_tvalid));
            if (vt[v].e_tvalid) begin
                chk($sformatf("vec%0d_tlast", v), 32'(f2u_tlast), 32'(vt[v].e_tlast));
                chk($sformatf("vec%0d_tzlp", v), 32'(f2u_tzlp), 32'(vt[v].e_tzlp));
                chk($sformatf("vec%0d_tdata", v), f2u_tdata, vt[v].e_tdata);
            end
        end

        // U2F: host pushes 1..16, master burst-reads with 2-cycle data latency.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            host_push(32'(i));
            if (i == 1)  chk("u2f_flagc_first", 32'(flagc), 32'd1);
            if (i == 15) chk("u2f_flagd_15", 32'(flagd), 32'd0);
            if (i == 16) chk("u2f_flagd_16", 32'(flagd), 32'd1);
        end
        cs_n = 1'b0; oe_n = 1'b0; ad = 2'b00; rd_n = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            rd_q.push_back('{32'(i), cyc + 2});
            tick();
        end
        rd_n = 1'b1;
        chk("u2f_flagc_after_last_pop", 32'(flagc), 32'd0);
        repeat (2) tick();
        chk("u2f_read_left", 32'(rd_q.size()), 32'd0);
        chk("u2f_no_unf", 32'(err_unf), 32'd0);
        idle();

        // F2U: 8-word packet ending on A7, then a lone pktend (ZLP).
        do_reset();
        cs_n = 1'b0; ad = 2'b11; tb_drv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_n = 1'b0;
            tb_dt = 32'h0000_00A0 + 32'(i);
            pktend_n = (i == 7) ? 1'b0 : 1'b1;
            f2u_q.push_back('{1'b0, (i == 7), tb_dt});
            tick();
        end
        wr_n = 1'b1; pktend_n = 1'b0;
        f2u_q.push_back('{1'b1, 1'b1, 32'h0});
        tick();
        idle();
        drain(40);

        // F2U fill to depth, overflow write dropped, one pop reopens FLAGA.
        do_reset();
        cs_n = 1'b0; ad = 2'b11; tb_drv = 1'b1; wr_n = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            tb_dt = 32'h0001_0000 + 32'(i);
            f2u_q.push_back('{1'b0, 1'b0, tb_dt});
            tick();
            if (i == int'(DEPTH - WMARK) - 1) chk("f2u_flagb_space16", 32'(flagb), 32'd1);
            if (i == int'(DEPTH - WMARK))     chk("f2u_flagb_space15", 32'(flagb), 32'd0);
            if (i == int'(DEPTH) - 2)         chk("f2u_flaga_one_free", 32'(flaga), 32'd1);
            if (i == int'(DEPTH) - 1)         chk("f2u_flaga_full", 32'(flaga), 32'd0);
        end
        chk("f2u_no_ovf_yet", 32'(err_ovf), 32'd0);
        tb_dt = 32'hDEAD_DEAD;
        tick();
        idle();
        chk("f2u_err_ovf", 32'(err_ovf), 32'd1);
        chk("f2u_flaga_still_full", 32'(flaga), 32'd0);
        f2u_tready = 1'b1;
        chk("f2u_first_tvalid", 32'(f2u_tvalid), 32'd1);
        chk("f2u_first_tdata", f2u_tdata, f2u_q[0].data);
        void'(f2u_q.pop_front());
        tick();
        f2u_tready = 1'b0;
        chk("f2u_flaga_after_pop", 32'(flaga), 32'd1);
        drain(600);

        // RD_N and WR_N together: protocol error, neither buffer moves.
        do_reset();
        host_push(32'h0000_0077);
        cs_n = 1'b0; oe_n = 1'b0; ad = 2'b00; rd_n = 1'b0; wr_n = 1'b0;
        tick();
        wr_n = 1'b1; rd_n = 1'b1;
        chk("both_err_proto", 32'(err_proto), 32'd1);
        chk("both_flagc_kept", 32'(flagc), 32'd1);
        chk("both_f2u_empty", 32'(f2u_tvalid), 32'd0);
        chk("both_no_unf", 32'(err_unf), 32'd0);
        rd_n = 1'b0;
        rd_q.push_back('{32'h0000_0077, cyc + 2});
        tick();
        rd_q.push_back('{32'h0000_0000, cyc + 2});
        tick();
        rd_n = 1'b1;
        chk("empty_read_err_unf", 32'(err_unf), 32'd1);
        tick();
        chk("both_read_left", 32'(rd_q.size()), 32'd0);
        idle();

        // Reset asserted mid-burst, between clock edges.
        do_reset();
        for (int i = 0; i < 8; i++) host_push(32'h0000_0051 + 32'(i));
        cs_n = 1'b0; ad = 2'b00; rd_n = 1'b0; wr_n = 1'b0;
        tick();
        wr_n = 1'b1;
        chk("midrst_pre_proto", 32'(err_proto), 32'd1);
        oe_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_q.push_back('{32'h0000_0051 + 32'(i), cyc + 2});
            tick();
        end
        #2;
        rst_n = 1'b0;
        tb_drv = 1'b1; tb_dt = 32'h0000_1234;
        rd_q.delete();
        #1;
        chk("midrst_sl_dt_released", sl_dt, 32'h0000_1234);
        chk("midrst_flagc", 32'(flagc), 32'd0);
        chk("midrst_flaga", 32'(flaga), 32'd1);
        chk("midrst_errs", {29'd0, err_ovf, err_unf, err_proto}, 32'd0);
        chk("midrst_tready", 32'(u2f_tready), 32'd0);
        idle();
        tick();
        rst_n = 1'b1;
        tick();
        chk("postrst_flagc", 32'(flagc), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
